// File: rtl/test_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_cmd_parser_pkg
// Description : Shared command codes, error codes and parser FSM encoding
//               for the UART test command parser.
// Revision    : 1.0 - initial release
// ============================================================================
package test_cmd_parser_pkg;

    // Host command codes understood by the test core
    localparam logic [7:0] CMD_GET_ECHO   = 8'h01;
    localparam logic [7:0] CMD_WRITE_DEST = 8'h02;
    localparam logic [7:0] CMD_READ_SRC   = 8'h03;
    localparam logic [7:0] CMD_START_LOOP = 8'h04;
    localparam logic [7:0] CMD_STOP_LOOP  = 8'h05;
    localparam logic [7:0] CMD_READ_CYCLE = 8'h06;
    localparam logic [7:0] CMD_SET_DELAY  = 8'h07;

    // Error codes reported on o_err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNKNOWN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Parser FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ARG  = 3'd1,
        ST_CHECK    = 3'd2,
        ST_ECHO     = 3'd3,
        ST_DISPATCH = 3'd4,
        ST_PAYLOAD  = 3'd5,
        ST_DRAIN    = 3'd6
    } state_e;

    // True for every command code the parser accepts
    function automatic logic is_known_cmd(input logic [7:0] code);
        case (code)
            CMD_GET_ECHO, CMD_WRITE_DEST, CMD_READ_SRC, CMD_START_LOOP,
            CMD_STOP_LOOP, CMD_READ_CYCLE, CMD_SET_DELAY: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_cmd_parser_timeout.sv
`default_nettype none
// ============================================================================
// Module      : cmd_timeout_counter
// Description : Saturating inter-byte timeout counter with synchronous clear
//               and count enable; flags expiry once LIMIT cycles elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout_counter
    import test_cmd_parser_pkg::*;
#(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] C_LIMIT = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over enable; counting stops at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/test_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : test_cmd_parser
// Description : Assembles 2-byte host command frames from the UART RX FIFO,
//               echoes GET_ECHO locally, hands other commands to the test
//               core and streams the WRITE_DEST payload bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module test_cmd_parser
    import test_cmd_parser_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 28,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_rd,
    input  logic       i_tx_rdy,
    output logic       o_tx_wr,
    output logic [7:0] o_tx_data,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd,
    output logic [7:0] o_cmd_arg,
    input  logic       i_cmd_rdy,
    output logic       o_pl_valid,
    output logic [7:0] o_pl_data,
    input  logic       i_pl_rdy,
    output logic       o_err,
    output logic [1:0] o_err_code,
    input  logic       i_err_clr
);

    localparam int unsigned CW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(PAYLOAD_BYTES - 1);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    pl_data_q, pl_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          pl_valid_q, pl_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blank_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic          can_pop;
    logic          pop;
    logic          err_set;
    logic [1:0]    err_new;
    logic          tmo_en;
    logic          tmo_exp;

    // The cycle after a pop is blanked because the FIFO head is still stale
    assign can_pop = i_rst_n && i_rx_valid && !blank_q;

    cmd_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (pop || !tmo_en),
        .i_en      (tmo_en),
        .o_expired (tmo_exp)
    );

    // Next-state, pop decision and registered-output next values
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        tx_data_d   = tx_data_q;
        pl_data_d   = pl_data_q;
        tx_wr_d     = 1'b0;
        cmd_valid_d = cmd_valid_q;
        pl_valid_d  = pl_valid_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        err_set     = 1'b0;
        err_new     = ERR_NONE;
        tmo_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    cmd_d   = i_rx_data;
                    state_d = ST_GET_ARG;
                end
            end
            ST_GET_ARG: begin
                tmo_en = 1'b1;
                if (can_pop) begin
                    pop     = 1'b1;
                    arg_d   = i_rx_data;
                    state_d = ST_CHECK;
                end else if (tmo_exp) begin
                    err_set = 1'b1;
                    err_new = ERR_TIMEOUT;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cmd_q == CMD_GET_ECHO) begin
                    state_d = ST_ECHO;
                end else if (is_known_cmd(cmd_q)) begin
                    cmd_valid_d = 1'b1;
                    state_d     = ST_DISPATCH;
                end else begin
                    err_set = 1'b1;
                    err_new = ERR_UNKNOWN;
                    state_d = ST_IDLE;
                end
            end
            ST_ECHO: begin
                if (i_tx_rdy) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = arg_q;
                    state_d   = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (i_cmd_rdy) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (cmd_q == CMD_WRITE_DEST) ? ST_PAYLOAD : ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (pl_valid_q) begin
                    if (i_pl_rdy) begin
                        pl_valid_d = 1'b0;
                        cnt_d      = cnt_q + CW'(1);
                        if (cnt_q == C_LAST) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    tmo_en = 1'b1;
                    if (can_pop) begin
                        pop        = 1'b1;
                        pl_data_d  = i_rx_data;
                        pl_valid_d = 1'b1;
                    end else if (tmo_exp) begin
                        err_set = 1'b1;
                        err_new = ERR_TIMEOUT;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (can_pop) begin
                    pop = 1'b1;
                end else if (!blank_q && !i_rx_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            arg_q       <= '0;
            tx_data_q   <= '0;
            pl_data_q   <= '0;
            tx_wr_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            pl_valid_q  <= 1'b0;
            cnt_q       <= '0;
            blank_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            tx_data_q   <= tx_data_d;
            pl_data_q   <= pl_data_d;
            tx_wr_q     <= tx_wr_d;
            cmd_valid_q <= cmd_valid_d;
            pl_valid_q  <= pl_valid_d;
            cnt_q       <= cnt_d;
            blank_q     <= pop;
        end
    end

    // Sticky error flag: clear has priority, first error keeps its code
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (i_err_clr) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (err_set && !err_q) begin
            err_q      <= 1'b1;
            err_code_q <= err_new;
        end
    end

    assign o_rx_rd     = pop;
    assign o_tx_wr     = tx_wr_q;
    assign o_tx_data   = tx_data_q;
    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_cmd_arg   = arg_q;
    assign o_pl_valid  = pl_valid_q;
    assign o_pl_data   = pl_data_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_test_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_cmd_parser
// Description : Self-checking bench for test_cmd_parser: directed vector
//               table, multi-cycle corner sequences and a randomized frame
//               stream checked against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_cmd_parser;
    import test_cmd_parser_pkg::*;

    localparam int PB = 28;
    localparam int TO = 100;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_rdy   = 1'b0;
    logic       cmd_rdy  = 1'b0;
    logic       pl_rdy   = 1'b0;
    logic       err_clr  = 1'b0;
    logic       rx_rd, tx_wr, cmd_valid, pl_valid, err;
    logic [7:0] tx_data, cmd, cmd_arg, pl_data;
    logic [1:0] err_code;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  pl_log[$];
    logic [15:0] cmd_log[$];
    int          cyc = 0, pops = 0, last_pop = 0, tx_lat = -1, cmd_lat = -1;
    logic        rd_seen;
    logic        prev_cv = 1'b0;

    always #5 clk = ~clk;

    test_cmd_parser #(
        .PAYLOAD_BYTES  (PB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_rd     (rx_rd),
        .i_tx_rdy    (tx_rdy),
        .o_tx_wr     (tx_wr),
        .o_tx_data   (tx_data),
        .o_cmd_valid (cmd_valid),
        .o_cmd       (cmd),
        .o_cmd_arg   (cmd_arg),
        .i_cmd_rdy   (cmd_rdy),
        .o_pl_valid  (pl_valid),
        .o_pl_data   (pl_data),
        .i_pl_rdy    (pl_rdy),
        .o_err       (err),
        .o_err_code  (err_code),
        .i_err_clr   (err_clr)
    );

    // Remember whether the FIFO was popped at this edge
    always @(posedge clk) rd_seen <= rx_rd;

    // RX FIFO model plus transaction monitor (mid-cycle sampling)
    initial forever begin
        @(negedge clk);
        if (rd_seen === 1'b1 && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_valid = (rx_q.size() != 0);
        rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        #1;
        cyc++;
        if (rx_rd === 1'b1) begin pops++; last_pop = cyc; end
        if (tx_wr === 1'b1) begin tx_log.push_back(tx_data); tx_lat = cyc - last_pop; end
        if (cmd_valid === 1'b1 && !prev_cv) cmd_lat = cyc - last_pop;
        prev_cv = (cmd_valid === 1'b1);
        if (cmd_valid === 1'b1 && cmd_rdy) cmd_log.push_back({cmd, cmd_arg});
        if (pl_valid === 1'b1 && pl_rdy) pl_log.push_back(pl_data);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_err();
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
    endtask

    task automatic clear_logs();
        tx_log.delete(); cmd_log.delete(); pl_log.delete();
        tx_lat = -1; cmd_lat = -1;
    endtask

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        rx_q.push_back(a); rx_q.push_back(b);
    endtask

    typedef struct {
        logic [7:0] c;
        logic [7:0] a;
        int         ntx;
        int         ncmd;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0]  sent[$];
        logic [7:0]  stream[$];
        logic [7:0]  exp_tx[$];
        logic [7:0]  exp_pl[$];
        logic [15:0] exp_cmd[$];
        logic [7:0]  known[7];
        logic [7:0]  b, c, a;
        logic        ok, kn, m_err;
        logic [1:0]  m_code;
        int          k, p0, idx, r;

        vecs[0] = '{CMD_GET_ECHO,   8'hA5, 1, 0, ERR_NONE};
        vecs[1] = '{CMD_START_LOOP, 8'h00, 0, 1, ERR_NONE};
        vecs[2] = '{CMD_READ_SRC,   8'h3C, 0, 1, ERR_NONE};
        vecs[3] = '{CMD_STOP_LOOP,  8'hFF, 0, 1, ERR_NONE};
        vecs[4] = '{CMD_READ_CYCLE, 8'h01, 0, 1, ERR_NONE};
        vecs[5] = '{CMD_SET_DELAY,  8'h80, 0, 1, ERR_NONE};
        vecs[6] = '{8'hEE,          8'h12, 0, 0, ERR_UNKNOWN};
        vecs[7] = '{8'h00,          8'h55, 0, 0, ERR_UNKNOWN};
        known   = '{CMD_GET_ECHO, CMD_WRITE_DEST, CMD_READ_SRC, CMD_START_LOOP,
                    CMD_STOP_LOOP, CMD_READ_CYCLE, CMD_SET_DELAY};

        // ---------------- reset state ----------------
        tick(3);
        check("reset_outputs", {rx_rd, tx_wr, tx_data, cmd_valid, cmd, cmd_arg,
                                pl_valid, pl_data, err, err_code}, 64'd0);
        rst_n = 1'b1;
        tick(2);

        // ---------------- single-frame vector table ----------------
        tx_rdy = 1'b1; cmd_rdy = 1'b1; pl_rdy = 1'b1;
        foreach (vecs[i]) begin
            clear_logs();
            p0 = pops;
            push2(vecs[i].c, vecs[i].a);
            tick(15);
            check("vec_tx_count", tx_log.size(), vecs[i].ntx);
            check("vec_cmd_count", cmd_log.size(), vecs[i].ncmd);
            check("vec_pops", pops - p0, 2);
            check("vec_err", {err, err_code}, {vecs[i].code != ERR_NONE, vecs[i].code});
            if (tx_log.size() > 0) begin
                check("vec_tx_data", tx_log[0], vecs[i].a);
                check("echo_latency", tx_lat, 3);
            end
            if (cmd_log.size() > 0) begin
                check("vec_cmd_data", cmd_log[0], {vecs[i].c, vecs[i].a});
                check("cmd_latency", cmd_lat, 2);
            end
            clear_err();
            check("err_cleared", {err, err_code}, 64'd0);
        end

        // ---------------- dispatch hold with back-pressure ----------------
        clear_logs();
        cmd_rdy = 1'b0;
        push2(CMD_START_LOOP, 8'h00);
        k = 0;
        while (cmd_valid !== 1'b1 && k < 50) begin tick(1); k++; end
        check("hold_seen", cmd_valid, 1);
        ok = 1'b1;
        repeat (10) begin
            if (!(cmd_valid === 1'b1 && cmd == CMD_START_LOOP && cmd_arg == 8'h00)) ok = 1'b0;
            tick(1);
        end
        check("hold_stable", ok, 1);
        cmd_rdy = 1'b1;
        check("hold_valid_at_rdy", cmd_valid, 1);
        tick(1);
        check("hold_drop", cmd_valid, 0);
        check("hold_handshakes", cmd_log.size(), 1);

        // ---------------- WRITE_DEST payload, toggling ready ----------------
        clear_logs();
        sent.delete();
        push2(CMD_WRITE_DEST, 8'h00);
        for (int i = 0; i < PB; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            rx_q.push_back(b);
        end
        k = 0;
        while (pl_log.size() < PB && k < 2000) begin
            pl_rdy = ((k / 3) % 2) == 1;
            tick(1);
            k++;
        end
        pl_rdy = 1'b1;
        tick(20);
        check("pl_count", pl_log.size(), PB);
        for (int i = 0; i < PB && i < pl_log.size(); i++) check("pl_data", pl_log[i], sent[i]);
        check("pl_cmd_handshake", cmd_log.size(), 1);
        tx_log.delete();
        push2(CMD_GET_ECHO, 8'h77);
        tick(15);
        check("post_pl_echo_count", tx_log.size(), 1);
        if (tx_log.size() > 0) check("post_pl_echo_data", tx_log[0], 8'h77);
        check("post_pl_no_extra", pl_log.size(), PB);

        // ---------------- inter-byte timeout ----------------
        clear_logs();
        p0 = pops;
        rx_q.push_back(CMD_START_LOOP);
        k = 0;
        while (pops == p0 && k < 50) begin tick(1); k++; end
        check("tmo_cmd_pop", pops - p0, 1);
        tick(95);
        check("tmo_not_early", err, 0);
        k = 0;
        while (err !== 1'b1 && k < 15) begin tick(1); k++; end
        check("tmo_err", {err, err_code}, {1'b1, ERR_TIMEOUT});
        check("tmo_no_cmd", cmd_log.size(), 0);
        clear_err();
        push2(CMD_GET_ECHO, 8'h5A);
        tick(15);
        check("tmo_echo_count", tx_log.size(), 1);
        if (tx_log.size() > 0) check("tmo_echo_data", tx_log[0], 8'h5A);

        // ---------------- reset in the middle of a payload ----------------
        clear_logs();
        push2(CMD_WRITE_DEST, 8'h01);
        for (int i = 0; i < PB; i++) rx_q.push_back(8'($urandom));
        k = 0;
        while (pl_log.size() < 10 && k < 500) begin tick(1); k++; end
        check("mid_reached", pl_log.size() >= 10, 1);
        rst_n = 1'b0;
        tick(1);
        check("mid_reset_outputs", {rx_rd, tx_wr, tx_data, cmd_valid, cmd, cmd_arg,
                                    pl_valid, pl_data, err, err_code}, 64'd0);
        rx_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clear_logs();
        push2(CMD_GET_ECHO, 8'h3C);
        tick(15);
        check("post_reset_echo_count", tx_log.size(), 1);
        if (tx_log.size() > 0) check("post_reset_echo_data", tx_log[0], 8'h3C);

        // ---------------- randomized frame stream ----------------
        clear_err();
        clear_logs();
        stream.delete();
        for (int f = 0; f < 30; f++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       c = known[r];
            else if (r == 7) c = CMD_WRITE_DEST;
            else             c = 8'($urandom);
            stream.push_back(c);
            stream.push_back(8'($urandom));
            if (c == CMD_WRITE_DEST) repeat (PB) stream.push_back(8'($urandom));
        end
        // Frame-level model: what the host expects to see for this stream
        exp_tx.delete(); exp_cmd.delete(); exp_pl.delete();
        m_err = 1'b0; m_code = ERR_NONE;
        idx = 0;
        while (idx < stream.size()) begin
            c = stream[idx]; a = stream[idx + 1]; idx += 2;
            kn = 1'b0;
            foreach (known[j]) if (c == known[j]) kn = 1'b1;
            if (!kn) begin
                if (!m_err) begin m_err = 1'b1; m_code = ERR_UNKNOWN; end
            end else if (c == CMD_GET_ECHO) begin
                exp_tx.push_back(a);
            end else begin
                exp_cmd.push_back({c, a});
                if (c == CMD_WRITE_DEST)
                    for (int j = 0; j < PB; j++) begin exp_pl.push_back(stream[idx]); idx++; end
            end
        end
        foreach (stream[i]) rx_q.push_back(stream[i]);
        k = 0;
        while ((rx_q.size() != 0 || tx_log.size() < exp_tx.size() || cmd_log.size() < exp_cmd.size()
                || pl_log.size() < exp_pl.size()) && k < 20000) begin
            tx_rdy  = 1'($urandom_range(0, 1));
            cmd_rdy = 1'($urandom_range(0, 1));
            pl_rdy  = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        tx_rdy = 1'b1; cmd_rdy = 1'b1; pl_rdy = 1'b1;
        tick(10);
        check("rnd_tx_count", tx_log.size(), exp_tx.size());
        check("rnd_cmd_count", cmd_log.size(), exp_cmd.size());
        check("rnd_pl_count", pl_log.size(), exp_pl.size());
        foreach (exp_tx[i])  if (i < tx_log.size())  check("rnd_tx", tx_log[i], exp_tx[i]);
        foreach (exp_cmd[i]) if (i < cmd_log.size()) check("rnd_cmd", cmd_log[i], exp_cmd[i]);
        foreach (exp_pl[i])  if (i < pl_log.size())  check("rnd_pl", pl_log[i], exp_pl[i]);
        check("rnd_err", {err, err_code}, {m_err, m_code});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/test_cmd_parser.md
Name: test_cmd_parser

Overview:
- Sits between the UART receive/transmit FIFOs and the test core.
- Pops host bytes from the UART RX FIFO and assembles 2-byte command frames (command, argument).
- Answers GET_ECHO locally through the UART TX FIFO.
- Passes every other valid command to the test core on a valid/ready handshake. After WRITE_DEST it also streams the following PAYLOAD_BYTES data bytes to the test core.

Parameters:
- PAYLOAD_BYTES, 28, number of data bytes that follow a WRITE_DEST frame.
- TIMEOUT_CYCLES, 1_000_000, maximum i_clk cycles allowed between consecutive bytes of one frame or payload.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_rx_valid  in  1  UART RX FIFO not empty; i_rx_data is valid.
- i_rx_data  in  8  head byte of the UART RX FIFO.
- o_rx_rd  out  1  one-cycle pop pulse to the RX FIFO.
- i_tx_rdy  in  1  UART TX FIFO can accept a byte.
- o_tx_wr  out  1  one-cycle write pulse to the TX FIFO.
- o_tx_data  out  8  byte to transmit.
- o_cmd_valid  out  1  command available for the test core.
- o_cmd  out  8  command code.
- o_cmd_arg  out  8  argument byte.
- i_cmd_rdy  in  1  test core accepts the command.
- o_pl_valid  out  1  payload byte valid.
- o_pl_data  out  8  payload byte.
- i_pl_rdy  in  1  test core accepts the payload byte.
- o_err  out  1  sticky error flag.
- o_err_code  out  2  error code: 0 none, 1 unknown command, 2 timeout.
- i_err_clr  in  1  clears o_err and o_err_code.

Behaviour:
- Reset (i_rst_n = 0 at a rising edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The timeout counter is cleared.
  - A reset in any state aborts the frame in progress with no further pops.
- Pop rule: the parser samples i_rx_data when i_rx_valid = 1 and pulses o_rx_rd for exactly one cycle. It ignores i_rx_valid on the next cycle to allow for FIFO update latency, so at most one pop occurs every 2 cycles.
- FSM states: IDLE, GET_ARG, CHECK, ECHO, DISPATCH, PAYLOAD, DRAIN.
  - IDLE: on i_rx_valid, pop and latch the byte into the command register, then go to GET_ARG.
  - GET_ARG: on i_rx_valid, pop and latch the byte into the argument register, then go to CHECK. The timeout counter runs; if it expires, set o_err_code = 2 and return to IDLE.
  - CHECK (1 cycle):
    - GET_ECHO goes to ECHO.
    - Any other known command goes to DISPATCH.
    - An unknown code sets o_err_code = 1 and returns to IDLE (the argument is already consumed).
  - ECHO: wait for i_tx_rdy, then pulse o_tx_wr for 1 cycle with o_tx_data = argument, then go to IDLE.
  - DISPATCH:
    - Hold o_cmd_valid = 1 with o_cmd and o_cmd_arg stable until the cycle where i_cmd_rdy = 1.
    - On that cycle, go to PAYLOAD if the command is WRITE_DEST, otherwise IDLE.
    - There is no timeout in this state.
  - PAYLOAD:
    - Byte counter runs 0..PAYLOAD_BYTES-1.
    - On i_rx_valid with o_pl_valid = 0: pop the byte into o_pl_data and set o_pl_valid.
    - o_pl_valid stays high until i_pl_rdy. On that handshake, clear o_pl_valid and increment the counter.
    - After the last handshake, return to IDLE.
    - The RX FIFO is never popped while o_pl_valid = 1; back-pressure lives in the RX FIFO.
    - The timeout counter applies only while waiting for i_rx_valid. On expiry, set code 2, go to DRAIN, and report no partial payload to the core.
  - DRAIN: pop and discard bytes while i_rx_valid, then return to IDLE once the FIFO is empty.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared on every pop and on entry to IDLE.
  - Saturates at expiry.
- o_err:
  - Set in the cycle an error is detected.
  - If errors coincide, the first one wins; o_err_code is not overwritten while o_err = 1.
  - i_err_clr takes priority over a simultaneous new error.
- Latency:
  - The echo byte is written 3 cycles after the argument pop when i_tx_rdy = 1.
  - o_cmd_valid rises 2 cycles after the argument pop.

Decomposition:
- Command codes (GET_ECHO, WRITE_DEST, READ_SRC, START_LOOP, STOP_LOOP, READ_CYCLE, SET_DELAY) come from the shared test_core defines header.
- Error codes and FSM state encodings are added to the same header.
- One sub-module: cmd_timeout_counter (load/clear, enable, expiry flag), reused for the GET_ARG and PAYLOAD waits.

Test Plan:
- GET_ECHO then 0xA5 -> one o_tx_wr with o_tx_data = 0xA5; o_cmd_valid is never asserted.
- START_LOOP then 0x00, with i_cmd_rdy held low for 10 cycles -> o_cmd_valid held for 10 cycles with stable o_cmd = START_LOOP and o_cmd_arg = 0x00; it drops one cycle after the rdy cycle.
- WRITE_DEST then 0x00 then 28 random bytes, with i_pl_rdy toggling every 3 cycles -> exactly 28 payload handshakes in order, matching the sent data; FSM returns to IDLE.
- Unknown code 0xEE then 0x12 -> o_err = 1, o_err_code = 1, both bytes popped, no cmd/tx activity; i_err_clr clears the flag.
- Command byte only, then silence for TIMEOUT_CYCLES (override to 100) -> o_err_code = 2 at cycle 100; the next full GET_ECHO frame works.
- Reset asserted mid-payload (byte 10) -> all outputs 0 on the next edge, and a new frame is parsed correctly after release.
